mem_access_stage: RTL and testbench

Pipeline MEM stage between the EX/MEM register and MEM_WB. It turns EX/MEM load/store controls into a valid/ready request to a multi-cycle data memory. It aligns store data and byte enables, and sign- or zero-extends load data. While an access is outstanding it stalls the upstream pipeline and sends bubbles (WB control = 0) into MEM_WB.

---
 rtl/mem_access_stage.sv | 151 +++++++++++++++
 tb/tb_mem_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns EX/MEM load/store controls into a valid/ready request to a
// multi-cycle data memory, aligns store lanes, formats load data and stalls upstream meanwhile.
module mem_access_stage #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_valid,
  input  logic [1:0]        EX_WB_in,
  input  logic              EX_MemRead,
  input  logic              EX_MemWrite,
  input  logic [2:0]        EX_Funct3,
  input  logic [DATA_W-1:0] EX_ALURes,
  input  logic [DATA_W-1:0] EX_WriteData,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [DATA_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic [7:0]        dmem_req_be,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  output logic              stall,
  output logic              MEM_fault,
  output logic [1:0]        MEM_WB_out,
  output logic [DATA_W-1:0] MEM_ReadData,
  output logic [DATA_W-1:0] MEM_ALURes,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a request transfers on a cycle where dmem_req_valid && dmem_req_ready; once
  // valid is raised it stays high with every request field stable until that cycle. Exactly
  // one dmem_rsp_valid pulse follows each transferred request and is only honoured in WAIT.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_rdata_q;

  logic [2:0]        w_offset;
  logic [1:0]        w_size;
  logic [5:0]        w_shamt;
  logic [7:0]        w_size_mask;
  logic              w_misalign;
  logic              w_mem_op;
  logic              w_fault;
  logic              w_legal;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_load_fmt;

  assign w_offset = EX_ALURes[2:0];
  assign w_size   = EX_Funct3[1:0];
  assign w_shamt  = {w_offset, 3'b000};
  assign w_mem_op = EX_valid & (EX_MemRead | EX_MemWrite);

  always_comb begin
    w_size_mask = 8'h01;
    w_misalign  = 1'b0;
    case (w_size)
      2'd0: begin w_size_mask = 8'h01; w_misalign = 1'b0;           end
      2'd1: begin w_size_mask = 8'h03; w_misalign = w_offset[0];    end
      2'd2: begin w_size_mask = 8'h0F; w_misalign = |w_offset[1:0]; end
      default: begin w_size_mask = 8'hFF; w_misalign = |w_offset;   end
    endcase
  end

  assign w_fault = w_mem_op & ((EX_MemRead & EX_MemWrite) | (EX_Funct3 == 3'b111) |
                               (EX_MemWrite & EX_Funct3[2]) | w_misalign);
  assign w_legal = w_mem_op & ~w_fault;

  // Funct3[2] selects zero extension; doubles pass through untouched.
  assign w_shifted = dmem_rsp_rdata >> w_shamt;
  always_comb begin
    w_load_fmt = w_shifted;
    case (w_size)
      2'd0: w_load_fmt = {{56{w_shifted[7]  & ~EX_Funct3[2]}}, w_shifted[7:0]};
      2'd1: w_load_fmt = {{48{w_shifted[15] & ~EX_Funct3[2]}}, w_shifted[15:0]};
      2'd2: w_load_fmt = {{32{w_shifted[31] & ~EX_Funct3[2]}}, w_shifted[31:0]};
      default: w_load_fmt = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rdata_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_legal) r_state <= dmem_req_ready ? S_WAIT : S_REQ;
        S_REQ:  if (dmem_req_ready) r_state <= S_WAIT;
        S_WAIT: if (dmem_rsp_valid) begin
          r_rdata_q <= EX_MemRead ? w_load_fmt : '0;
          r_state   <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dmem_req_valid = 1'b0;
    dmem_req_we    = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_wdata = '0;
    dmem_req_be    = '0;
    stall          = 1'b0;
    MEM_fault      = 1'b0;
    MEM_WB_out     = 2'b00;
    MEM_ReadData   = '0;
    MEM_ALURes     = '0;
    if (rst) begin
      MEM_ALURes = EX_ALURes;
      case (r_state)
        S_IDLE: begin
          if (w_fault) begin
            MEM_fault = 1'b1;
          end else if (w_legal) begin
            dmem_req_valid = 1'b1;
            stall          = 1'b1;
          end else begin
            MEM_WB_out = EX_valid ? EX_WB_in : 2'b00;
          end
        end
        S_REQ: begin
          dmem_req_valid = 1'b1;
          stall          = 1'b1;
        end
        S_WAIT: stall = 1'b1;
        default: begin
          MEM_WB_out   = EX_WB_in;
          MEM_ReadData = r_rdata_q;
        end
      endcase
      // Request fields come from the held EX/MEM inputs, so they stay stable under backpressure.
      if (dmem_req_valid) begin
        dmem_req_we    = EX_MemWrite;
        dmem_req_addr  = {EX_ALURes[DATA_W-1:3], 3'b000};
        dmem_req_be    = w_size_mask << w_offset;
        dmem_req_wdata = EX_WriteData << w_shamt;
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single-cycle vectors plus hand-written
// multi-cycle sequences (loads, store backpressure, reset mid-access, back-to-back).
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        EX_valid;
  logic [1:0]  EX_WB_in;
  logic        EX_MemRead;
  logic        EX_MemWrite;
  logic [2:0]  EX_Funct3;
  logic [63:0] EX_ALURes;
  logic [63:0] EX_WriteData;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [63:0] dmem_req_addr;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        stall;
  logic        MEM_fault;
  logic [1:0]  MEM_WB_out;
  logic [63:0] MEM_ReadData;
  logic [63:0] MEM_ALURes;
  logic [1:0]  o_dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  mem_access_stage #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .EX_valid(EX_valid), .EX_WB_in(EX_WB_in),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_Funct3(EX_Funct3),
    .EX_ALURes(EX_ALURes), .EX_WriteData(EX_WriteData),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .stall(stall), .MEM_fault(MEM_fault), .MEM_WB_out(MEM_WB_out),
    .MEM_ReadData(MEM_ReadData), .MEM_ALURes(MEM_ALURes), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        ex_valid;
    logic [1:0]  wb_in;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] wd;
    logic        e_valid;
    logic        e_we;
    logic [63:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wdata;
    logic        e_stall;
    logic        e_fault;
    logic [1:0]  e_wb;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic drive_ex(input logic v, input logic [1:0] wb, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] wd);
    EX_valid = v; EX_WB_in = wb; EX_MemRead = rd; EX_MemWrite = wr;
    EX_Funct3 = f3; EX_ALURes = alu; EX_WriteData = wd;
  endtask

  task automatic add_vec(input string nm, input logic v, input logic [1:0] wb, input logic rd,
                         input logic wr, input logic [2:0] f3, input logic [63:0] alu,
                         input logic [63:0] wd, input logic ev, input logic ewe,
                         input logic [63:0] eaddr, input logic [7:0] ebe, input logic [63:0] ewd,
                         input logic est, input logic ef, input logic [1:0] ewb);
    vec_t t;
    t.name = nm; t.ex_valid = v; t.wb_in = wb; t.rd = rd; t.wr = wr; t.f3 = f3;
    t.alu = alu; t.wd = wd; t.e_valid = ev; t.e_we = ewe; t.e_addr = eaddr; t.e_be = ebe;
    t.e_wdata = ewd; t.e_stall = est; t.e_fault = ef; t.e_wb = ewb;
    vq.push_back(t);
  endtask

  task automatic run_load(input string nm, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
    @(posedge clk); #1;
    drive_ex(1'b1, 2'b11, 1'b1, 1'b0, f3, addr, 64'h0);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_req_valid"}, dmem_req_valid, 1'b1);
    chk({nm, "_req_stall"}, stall, 1'b1);
    chk({nm, "_req_wb"}, MEM_WB_out, 2'b00);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = rdata;
    @(negedge clk);
    chk({nm, "_wait_state"}, o_dbg_state, 2'd2);
    chk({nm, "_wait_valid"}, dmem_req_valid, 1'b0);
    chk({nm, "_wait_stall"}, stall, 1'b1);
    chk({nm, "_wait_wb"}, MEM_WB_out, 2'b00);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '1;
    @(negedge clk);
    chk({nm, "_done_state"}, o_dbg_state, 2'd3);
    chk({nm, "_done_stall"}, stall, 1'b0);
    chk({nm, "_done_wb"}, MEM_WB_out, 2'b11);
    chk({nm, "_done_data"}, MEM_ReadData, exp);
    #1 EX_valid = 1'b0;
  endtask

  initial begin
    int cyc, idx, writes, ld_wb_cyc, add_wb_cyc;
    logic rsp_next;
    logic [63:0] ld_data;

    // reset state with a live load presented and memory signals active
    rst = 1'b0;
    drive_ex(1'b1, 2'b11, 1'b1, 1'b0, 3'b011, 64'h8, 64'hFF);
    dmem_req_ready = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 64'h1234;
    #3;
    chk("rst_state", o_dbg_state, 2'd0);
    chk("rst_req_valid", dmem_req_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb", MEM_WB_out, 2'b00);
    chk("rst_alu", MEM_ALURes, 64'h0);
    chk("rst_addr", dmem_req_addr, 64'h0);
    chk("rst_rdata", MEM_ReadData, 64'h0);
    @(negedge clk);
    @(negedge clk);
    drive_ex(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    rst = 1'b1;

    // single-cycle vectors, all sampled in IDLE
    add_vec("alu_pass", 1, 2'b10, 0, 0, 3'b000, 64'h1234, 0,
            0, 0, 0, 8'h00, 0, 0, 0, 2'b10);
    add_vec("inv_wb_zero", 0, 2'b11, 0, 0, 3'b000, 64'h55, 0,
            0, 0, 0, 8'h00, 0, 0, 0, 2'b00);
    add_vec("inv_memread", 0, 2'b11, 1, 0, 3'b010, 64'h4002, 0,
            0, 0, 0, 8'h00, 0, 0, 0, 2'b00);
    add_vec("lb_req", 1, 2'b11, 1, 0, 3'b000, 64'h1003, 0,
            1, 0, 64'h1000, 8'h08, 0, 1, 0, 2'b00);
    add_vec("sb_req", 1, 2'b00, 0, 1, 3'b000, 64'h1003, 64'h11223344556677AB,
            1, 1, 64'h1000, 8'h08, 64'h44556677AB000000, 1, 0, 2'b00);
    add_vec("sh_req", 1, 2'b00, 0, 1, 3'b001, 64'h2006, 64'hBEEF,
            1, 1, 64'h2000, 8'hC0, 64'hBEEF000000000000, 1, 0, 2'b00);
    add_vec("sw_hi_req", 1, 2'b00, 0, 1, 3'b010, 64'h14, 64'hCAFEF00D,
            1, 1, 64'h10, 8'hF0, 64'hCAFEF00D00000000, 1, 0, 2'b00);
    add_vec("sd_req", 1, 2'b00, 0, 1, 3'b011, 64'h18, 64'h0123456789ABCDEF,
            1, 1, 64'h18, 8'hFF, 64'h0123456789ABCDEF, 1, 0, 2'b00);
    add_vec("lhu_req", 1, 2'b11, 1, 0, 3'b101, 64'h2A, 0,
            1, 0, 64'h28, 8'h0C, 0, 1, 0, 2'b00);
    add_vec("lw_misalign", 1, 2'b11, 1, 0, 3'b010, 64'h4002, 0,
            0, 0, 0, 8'h00, 0, 0, 1, 2'b00);
    add_vec("ld_misalign", 1, 2'b11, 1, 0, 3'b011, 64'h4, 0,
            0, 0, 0, 8'h00, 0, 0, 1, 2'b00);
    add_vec("lh_misalign", 1, 2'b11, 1, 0, 3'b001, 64'h1, 0,
            0, 0, 0, 8'h00, 0, 0, 1, 2'b00);
    add_vec("rsv_funct3", 1, 2'b11, 1, 0, 3'b111, 64'h0, 0,
            0, 0, 0, 8'h00, 0, 0, 1, 2'b00);
    add_vec("store_unsigned", 1, 2'b00, 0, 1, 3'b100, 64'h0, 0,
            0, 0, 0, 8'h00, 0, 0, 1, 2'b00);
    add_vec("rd_and_wr", 1, 2'b11, 1, 1, 3'b011, 64'h0, 0,
            0, 0, 0, 8'h00, 0, 0, 1, 2'b00);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive_ex(vq[i].ex_valid, vq[i].wb_in, vq[i].rd, vq[i].wr, vq[i].f3, vq[i].alu, vq[i].wd);
      @(negedge clk);
      chk({vq[i].name, "_state"}, o_dbg_state, 2'd0);
      chk({vq[i].name, "_valid"}, dmem_req_valid, vq[i].e_valid);
      chk({vq[i].name, "_we"}, dmem_req_we, vq[i].e_we);
      chk({vq[i].name, "_addr"}, dmem_req_addr, vq[i].e_addr);
      chk({vq[i].name, "_be"}, dmem_req_be, vq[i].e_be);
      chk({vq[i].name, "_wdata"}, dmem_req_wdata, vq[i].e_wdata);
      chk({vq[i].name, "_stall"}, stall, vq[i].e_stall);
      chk({vq[i].name, "_fault"}, MEM_fault, vq[i].e_fault);
      chk({vq[i].name, "_wb"}, MEM_WB_out, vq[i].e_wb);
      chk({vq[i].name, "_alu"}, MEM_ALURes, vq[i].alu);
      chk({vq[i].name, "_rdata"}, MEM_ReadData, 64'h0);
      #1 EX_valid = 1'b0;
    end

    // loads with immediate ready and one-cycle response
    run_load("lb", 3'b000, 64'h1003, 64'h0000000080000000, 64'hFFFFFFFFFFFFFF80);
    run_load("lbu", 3'b100, 64'h1003, 64'h0000000080000000, 64'h0000000000000080);
    run_load("lw", 3'b010, 64'h1004, 64'h8765432100000000, 64'hFFFFFFFF87654321);
    run_load("lhu", 3'b101, 64'h1006, 64'hF00D000000000000, 64'h000000000000F00D);

    // store half under 3 cycles of backpressure; a stray response in REQ must be ignored
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) drive_ex(1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF);
      dmem_rsp_valid = (c == 1);
      dmem_rsp_rdata = 64'hAAAA;
      dmem_req_ready = (c == 3);
      @(negedge clk);
      chk($sformatf("sh_bp%0d_state", c), o_dbg_state, (c == 0) ? 2'd0 : 2'd1);
      chk($sformatf("sh_bp%0d_valid", c), dmem_req_valid, 1'b1);
      chk($sformatf("sh_bp%0d_we", c), dmem_req_we, 1'b1);
      chk($sformatf("sh_bp%0d_addr", c), dmem_req_addr, 64'h2000);
      chk($sformatf("sh_bp%0d_be", c), dmem_req_be, 8'hC0);
      chk($sformatf("sh_bp%0d_wdata", c), dmem_req_wdata, 64'hBEEF000000000000);
      chk($sformatf("sh_bp%0d_stall", c), stall, 1'b1);
      chk($sformatf("sh_bp%0d_wb", c), MEM_WB_out, 2'b00);
    end
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("sh_wait0_state", o_dbg_state, 2'd2);
    chk("sh_wait0_valid", dmem_req_valid, 1'b0);
    chk("sh_wait0_stall", stall, 1'b1);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = '1;
    @(negedge clk);
    chk("sh_wait1_stall", stall, 1'b1);
    chk("sh_wait1_wb", MEM_WB_out, 2'b00);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("sh_done_state", o_dbg_state, 2'd3);
    chk("sh_done_stall", stall, 1'b0);
    chk("sh_done_rdata", MEM_ReadData, 64'h0);
    #1 EX_valid = 1'b0;

    // reset asserted mid-WAIT, then a late response after release
    @(posedge clk); #1;
    drive_ex(1'b1, 2'b11, 1'b1, 1'b0, 3'b011, 64'h8, 64'h0);
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    chk("rstw_pre_state", o_dbg_state, 2'd2);
    rst = 1'b0;
    #1;
    chk("rstw_state", o_dbg_state, 2'd0);
    chk("rstw_stall", stall, 1'b0);
    chk("rstw_alu", MEM_ALURes, 64'h0);
    chk("rstw_wb", MEM_WB_out, 2'b00);
    drive_ex(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 64'h1234;
    @(negedge clk);
    chk("late_rsp_state", o_dbg_state, 2'd0);
    chk("late_rsp_wb", MEM_WB_out, 2'b00);
    chk("late_rsp_stall", stall, 1'b0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_after_state", o_dbg_state, 2'd0);
    chk("late_rsp_after_rdata", MEM_ReadData, 64'h0);
    chk("late_rsp_after_wb", MEM_WB_out, 2'b00);

    // back-to-back: ld then add, bench acting as the upstream pipeline and memory
    cyc = 0; idx = 0; writes = 0; ld_wb_cyc = -1; add_wb_cyc = -1; ld_data = '0;
    @(posedge clk); #1;
    drive_ex(1'b1, 2'b11, 1'b1, 1'b0, 3'b011, 64'h8, 64'h0);
    dmem_req_ready = 1'b1;
    dmem_rsp_rdata = 64'h0123456789ABCDEF;
    while (idx < 2 && cyc < 12) begin
      @(negedge clk);
      if (MEM_WB_out != 2'b00) begin
        writes++;
        if (MEM_WB_out == 2'b11) begin ld_wb_cyc = cyc; ld_data = MEM_ReadData; end
        else if (MEM_WB_out == 2'b10) add_wb_cyc = cyc;
      end
      rsp_next = dmem_req_valid & dmem_req_ready;
      if (!stall) idx++;
      @(posedge clk); #1;
      cyc++;
      dmem_rsp_valid = rsp_next;
      if (idx == 1) drive_ex(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 64'h99, 64'h0);
      else if (idx >= 2) EX_valid = 1'b0;
    end
    chk("b2b_budget", (cyc < 12), 1'b1);
    chk("b2b_writes", writes, 2);
    chk("b2b_ld_cycle", ld_wb_cyc, 2);
    chk("b2b_add_cycle", add_wb_cyc, 3);
    chk("b2b_ld_data", ld_data, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk("b2b_idle_wb", MEM_WB_out, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
